// File: rtl/riscv_lsu.sv
// ============================================================================
// Module   : riscv_lsu
// Purpose  : RV32I load/store unit. It steers byte lanes for stores and
//            extends load data, and it stalls the core while the data memory
//            inserts wait states. Optional macro: RISCV_LSU_MISALIGN_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module riscv_lsu #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              x_reset,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              stall,
  output logic              done,
  output logic [31:0]       load_data,
  output logic              misaligned,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic              r_we;
  logic [2:0]        r_funct3;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [31:0]       r_load;
  logic              w_f3_ok;
  logic              w_skip;
  logic              w_accept;
  logic              w_mem_valid;
  logic [3:0]        w_be;
  logic [31:0]       w_wdata;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [31:0]       w_ext;

  always_comb begin
    w_f3_ok = 1'b0;
    if (req_we) begin
      w_f3_ok = (req_funct3 == 3'd0) || (req_funct3 == 3'd1) || (req_funct3 == 3'd2);
    end else begin
      w_f3_ok = (req_funct3 == 3'd0) || (req_funct3 == 3'd1) || (req_funct3 == 3'd2) ||
                (req_funct3 == 3'd4) || (req_funct3 == 3'd5);
    end
  end

`ifdef RISCV_LSU_MISALIGN_EN
  logic w_mis_req;
  logic r_mis;

  assign w_mis_req = w_f3_ok &&
                     (((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                      ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00)));
  assign w_skip    = !w_f3_ok || w_mis_req;
`else
  assign w_skip    = !w_f3_ok;
`endif

  assign w_accept = (r_state == S_IDLE) && req_valid;

  always_ff @(posedge clk or negedge x_reset) begin
    if (!x_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    stall       = 1'b0;
    done        = 1'b0;
    w_mem_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        stall = req_valid;
        if (req_valid) begin
          w_next = w_skip ? S_RESP : S_REQ;
        end
      end
      S_REQ: begin
        stall       = 1'b1;
        w_mem_valid = 1'b1;
        if (mem_ready) begin
          w_next = S_RESP;
        end
      end
      S_RESP: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Store lane steering; loads always read the full word.
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = r_wdata;
    if (r_we) begin
      case (r_funct3[1:0])
        2'b00: begin
          w_be    = 4'b0001 << r_addr[1:0];
          w_wdata = {4{r_wdata[7:0]}};
        end
        2'b01: begin
          w_be    = r_addr[1] ? 4'b1100 : 4'b0011;
          w_wdata = {2{r_wdata[15:0]}};
        end
        default: begin
          w_be    = 4'b1111;
          w_wdata = r_wdata;
        end
      endcase
    end
  end

  always_comb begin
    w_byte = mem_rdata[7:0];
    case (r_addr[1:0])
      2'b00:   w_byte = mem_rdata[7:0];
      2'b01:   w_byte = mem_rdata[15:8];
      2'b10:   w_byte = mem_rdata[23:16];
      default: w_byte = mem_rdata[31:24];
    endcase
    w_half = r_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    w_ext  = 32'd0;
    if (!r_we) begin
      case (r_funct3)
        3'd0:    w_ext = {{24{w_byte[7]}}, w_byte};
        3'd4:    w_ext = {24'd0, w_byte};
        3'd1:    w_ext = {{16{w_half[15]}}, w_half};
        3'd5:    w_ext = {16'd0, w_half};
        3'd2:    w_ext = mem_rdata;
        default: w_ext = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge x_reset) begin
    if (!x_reset) begin
      r_we     <= 1'b0;
      r_funct3 <= 3'd0;
      r_addr   <= '0;
      r_wdata  <= 32'd0;
      r_load   <= 32'd0;
    end else if (w_accept) begin
      r_we     <= req_we;
      r_funct3 <= req_funct3;
      r_addr   <= req_addr;
      r_wdata  <= req_wdata;
      r_load   <= 32'd0;
    end else if ((r_state == S_REQ) && mem_ready) begin
      r_load   <= w_ext;
    end
  end

`ifdef RISCV_LSU_MISALIGN_EN
  always_ff @(posedge clk or negedge x_reset) begin
    if (!x_reset) begin
      r_mis <= 1'b0;
    end else if (w_accept) begin
      r_mis <= w_mis_req;
    end
  end

  assign misaligned = done && r_mis;
`else
  assign misaligned = 1'b0;
`endif

  assign load_data = done ? r_load : 32'd0;
  assign mem_valid = w_mem_valid;
  assign mem_we    = w_mem_valid && r_we;
  assign mem_addr  = w_mem_valid ? {r_addr[ADDR_W-1:2], 2'b00} : '0;
  assign mem_be    = w_mem_valid ? w_be : 4'b0000;
  assign mem_wdata = w_mem_valid ? w_wdata : 32'd0;

endmodule

`default_nettype wire

// File: tb/tb_riscv_lsu.sv
// ============================================================================
// Module   : tb_riscv_lsu
// Purpose  : Directed vector bench for riscv_lsu, plus reset-abort sequence.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_riscv_lsu;

  logic        clk = 1'b0;
  logic        x_reset;
  logic        req_valid;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall;
  logic        done;
  logic [31:0] load_data;
  logic        misaligned;
  logic        mem_valid;
  logic        mem_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  riscv_lsu #(.ADDR_W(32)) dut (
    .clk        (clk),
    .x_reset    (x_reset),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .stall      (stall),
    .done       (done),
    .load_data  (load_data),
    .misaligned (misaligned),
    .mem_valid  (mem_valid),
    .mem_ready  (mem_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_be     (mem_be),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          waits;
    logic        issue;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
    logic [31:0] e_load;
    logic        e_mis;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    @(negedge clk);
    chk($sformatf("v%0d_idle_done", idx), 32'(done), 32'd0);
    req_valid  = 1'b1;
    req_we     = v.we;
    req_funct3 = v.f3;
    req_addr   = v.addr;
    req_wdata  = v.wdata;
    #1;
    chk($sformatf("v%0d_accept_stall", idx), 32'(stall), 32'd1);
    @(posedge clk);
    #1;
    // Junk on the request bus while busy must be ignored.
    req_valid  = 1'b1;
    req_we     = ~v.we;
    req_funct3 = 3'd2;
    req_addr   = 32'hFFFF_FFF0;
    req_wdata  = 32'h5A5A_5A5A;
    if (v.issue) begin
      for (int w = 0; w <= v.waits; w++) begin
        @(negedge clk);
        chk($sformatf("v%0d_w%0d_mem_valid", idx, w), 32'(mem_valid), 32'd1);
        chk($sformatf("v%0d_w%0d_mem_addr", idx, w), mem_addr, v.e_addr);
        chk($sformatf("v%0d_w%0d_mem_be", idx, w), 32'(mem_be), 32'(v.e_be));
        chk($sformatf("v%0d_w%0d_mem_we", idx, w), 32'(mem_we), 32'(v.we));
        if (v.we) chk($sformatf("v%0d_w%0d_mem_wdata", idx, w), mem_wdata, v.e_wdata);
        chk($sformatf("v%0d_w%0d_stall", idx, w), 32'(stall), 32'd1);
        chk($sformatf("v%0d_w%0d_done", idx, w), 32'(done), 32'd0);
        if (w == v.waits) begin
          mem_ready = 1'b1;
          mem_rdata = v.rdata;
        end else begin
          mem_ready = 1'b0;
          mem_rdata = ~v.rdata;
        end
      end
      @(posedge clk);
      #1;
      mem_ready = 1'b0;
      mem_rdata = 32'd0;
    end
    @(negedge clk);
    chk($sformatf("v%0d_done", idx), 32'(done), 32'd1);
    chk($sformatf("v%0d_resp_stall", idx), 32'(stall), 32'd0);
    chk($sformatf("v%0d_resp_mem_valid", idx), 32'(mem_valid), 32'd0);
    chk($sformatf("v%0d_load_data", idx), load_data, v.e_load);
    chk($sformatf("v%0d_misaligned", idx), 32'(misaligned), 32'(v.e_mis));
    req_valid = 1'b0;
  endtask

  initial begin
    //          we  f3    addr           wdata          rdata          wt iss e_addr         be       e_wdata        e_load         mis
    vecs[0]  = '{1'b1, 3'd2, 32'h0000_0104, 32'hDEAD_BEEF, 32'h0,         0, 1'b1, 32'h0000_0104, 4'b1111, 32'hDEAD_BEEF, 32'h0,         1'b0};
    vecs[1]  = '{1'b0, 3'd0, 32'h0000_0103, 32'h0,         32'h80FF_1234, 0, 1'b1, 32'h0000_0100, 4'b1111, 32'h0,         32'hFFFF_FF80, 1'b0};
    vecs[2]  = '{1'b0, 3'd4, 32'h0000_0103, 32'h0,         32'h80FF_1234, 0, 1'b1, 32'h0000_0100, 4'b1111, 32'h0,         32'h0000_0080, 1'b0};
    vecs[3]  = '{1'b0, 3'd1, 32'h0000_0102, 32'h0,         32'h80FF_1234, 0, 1'b1, 32'h0000_0100, 4'b1111, 32'h0,         32'hFFFF_80FF, 1'b0};
    vecs[4]  = '{1'b0, 3'd5, 32'h0000_0102, 32'h0,         32'h80FF_1234, 0, 1'b1, 32'h0000_0100, 4'b1111, 32'h0,         32'h0000_80FF, 1'b0};
    vecs[5]  = '{1'b1, 3'd1, 32'h0000_0202, 32'h0000_ABCD, 32'h0,         0, 1'b1, 32'h0000_0200, 4'b1100, 32'hABCD_ABCD, 32'h0,         1'b0};
    vecs[6]  = '{1'b1, 3'd1, 32'h0000_0200, 32'h0000_1234, 32'h0,         0, 1'b1, 32'h0000_0200, 4'b0011, 32'h1234_1234, 32'h0,         1'b0};
    vecs[7]  = '{1'b1, 3'd0, 32'h0000_0201, 32'h1234_5678, 32'h0,         0, 1'b1, 32'h0000_0200, 4'b0010, 32'h7878_7878, 32'h0,         1'b0};
    vecs[8]  = '{1'b0, 3'd2, 32'h0000_0100, 32'h0,         32'hCAFE_BABE, 5, 1'b1, 32'h0000_0100, 4'b1111, 32'h0,         32'hCAFE_BABE, 1'b0};
    vecs[9]  = '{1'b0, 3'd0, 32'h0000_0100, 32'h0,         32'h0000_007F, 1, 1'b1, 32'h0000_0100, 4'b1111, 32'h0,         32'h0000_007F, 1'b0};
    vecs[10] = '{1'b0, 3'd3, 32'h0000_0100, 32'h0,         32'h1111_1111, 0, 1'b0, 32'h0,         4'b0000, 32'h0,         32'h0,         1'b0};
    vecs[11] = '{1'b1, 3'd4, 32'h0000_0100, 32'h1111_1111, 32'h0,         0, 1'b0, 32'h0,         4'b0000, 32'h0,         32'h0,         1'b0};
`ifdef RISCV_LSU_MISALIGN_EN
    vecs[12] = '{1'b0, 3'd2, 32'h0000_0101, 32'h0,         32'h1122_3344, 0, 1'b0, 32'h0,         4'b0000, 32'h0,         32'h0,         1'b1};
    vecs[13] = '{1'b0, 3'd1, 32'h0000_0103, 32'h0,         32'h8001_0000, 0, 1'b0, 32'h0,         4'b0000, 32'h0,         32'h0,         1'b1};
    vecs[14] = '{1'b1, 3'd2, 32'h0000_0106, 32'h0102_0304, 32'h0,         0, 1'b0, 32'h0,         4'b0000, 32'h0,         32'h0,         1'b1};
`else
    vecs[12] = '{1'b0, 3'd2, 32'h0000_0101, 32'h0,         32'h1122_3344, 0, 1'b1, 32'h0000_0100, 4'b1111, 32'h0,         32'h1122_3344, 1'b0};
    vecs[13] = '{1'b0, 3'd1, 32'h0000_0103, 32'h0,         32'h8001_0000, 0, 1'b1, 32'h0000_0100, 4'b1111, 32'h0,         32'hFFFF_8001, 1'b0};
    vecs[14] = '{1'b1, 3'd2, 32'h0000_0106, 32'h0102_0304, 32'h0,         0, 1'b1, 32'h0000_0104, 4'b1111, 32'h0102_0304, 32'h0,         1'b0};
`endif
    vecs[15] = '{1'b0, 3'd0, 32'h0000_0102, 32'h0,         32'h00AB_0000, 0, 1'b1, 32'h0000_0100, 4'b1111, 32'h0,         32'hFFFF_FFAB, 1'b0};

    x_reset    = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'd0;
    req_addr   = 32'd0;
    req_wdata  = 32'd0;
    mem_ready  = 1'b0;
    mem_rdata  = 32'd0;

    repeat (2) @(negedge clk);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_load_data", load_data, 32'd0);
    chk("rst_misaligned", 32'(misaligned), 32'd0);
    chk("rst_mem_valid", 32'(mem_valid), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_be", 32'(mem_be), 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    x_reset = 1'b1;

    for (int i = 0; i < NV; i++) begin
      run_vec(vecs[i], i);
    end

    // Reset asserted while a store is waiting on memory.
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'd2;
    req_addr   = 32'h0000_0300;
    req_wdata  = 32'h1111_2222;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("abort_pre_mem_valid", 32'(mem_valid), 32'd1);
    #1;
    x_reset = 1'b0;
    #1;
    chk("abort_mem_valid", 32'(mem_valid), 32'd0);
    chk("abort_stall", 32'(stall), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_mem_be", 32'(mem_be), 32'd0);
    @(negedge clk);
    chk("abort_hold_done", 32'(done), 32'd0);
    x_reset = 1'b1;
    @(negedge clk);
    chk("abort_after_done", 32'(done), 32'd0);
    chk("abort_after_mem_valid", 32'(mem_valid), 32'd0);

    run_vec('{1'b1, 3'd2, 32'h0000_0300, 32'h1111_2222, 32'h0, 0, 1'b1,
              32'h0000_0300, 4'b1111, 32'h1111_2222, 32'h0, 1'b0}, 99);

    @(negedge clk);
    chk("final_idle_done", 32'(done), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/riscv_lsu.md
Name: riscv_lsu

Overview:
Load/store unit between the core's data-side datapath (ALU address, rs2 data, store enable, funct3) and a data memory port that can insert wait states.
- Stores: performs byte-lane steering of write data.
- Loads: extracts and sign- or zero-extends the selected byte, half or word.
- Holds the core with a stall signal until each access completes.
- Load result feeds the write-back mux.

Parameters:
ADDR_W, 32, byte address width of req_addr and mem_addr.

Ports:
clk  in  1  system clock
x_reset  in  1  asynchronous active-low reset
req_valid  in  1  core presents a load/store this cycle
req_we  in  1  1 = store, 0 = load
req_funct3  in  3  RV32I size/sign code: 0 LB/SB, 1 LH/SH, 2 LW/SW, 4 LBU, 5 LHU
req_addr  in  ADDR_W  byte address
req_wdata  in  32  store data (rs2)
stall  out  1  core must hold PC and register state
done  out  1  one-cycle pulse when the access completes
load_data  out  32  extended load result, valid while done=1
misaligned  out  1  misalignment flag, pulses with done (see Optional Feature)
mem_valid  out  1  memory request
mem_ready  in  1  memory accepts the request; for loads, mem_rdata is valid the same cycle
mem_we  out  1  write strobe
mem_addr  out  ADDR_W  word-aligned address, {req_addr[ADDR_W-1:2],2'b00}
mem_be  out  4  byte enables
mem_wdata  out  32  lane-replicated store data
mem_rdata  in  32  read data

Behaviour:
- Reset: async on x_reset=0. State to IDLE. All outputs 0. Any in-flight transaction is abandoned; mem_valid drops immediately and no done pulse occurs.
- State IDLE:
  - stall = req_valid (combinational).
  - With req_valid=1, latch we/funct3/addr/wdata.
  - Valid funct3 → REQ.
  - Invalid funct3 (load 3/6/7, store ≥3) → RESP with no memory access; load_data = 0.
- State REQ:
  - mem_valid=1; mem_we/addr/be/wdata come from latched values and stay stable until mem_ready.
  - stall=1.
  - On mem_ready=1, register mem_rdata and go to RESP.
- State RESP:
  - done=1, stall=0, mem_valid=0.
  - load_data is valid (0 for stores).
  - req_* inputs are ignored. Next state is IDLE.
- req_* inputs are sampled only in IDLE.
- Latency: accept cycle N. With mem_ready high on first assertion, mem_valid is high in N+1 and done in N+2. Each wait cycle adds one.
- Store lanes:
  - SB: be = 4'b0001 << addr[1:0]; wdata = byte replicated ×4.
  - SH: be = addr[1] ? 4'b1100 : 4'b0011; wdata = half replicated ×2.
  - SW: be = 4'b1111; wdata unchanged.
- Loads: mem_we=0, be=4'b1111.
  - Byte = rdata[8*addr[1:0]+:8].
  - Half = rdata[16*addr[1]+:16].
  - Sign-extend for LB/LH, zero-extend for LBU/LHU. LW passes through.
- Back-to-back requests: the next request can be accepted in the IDLE cycle right after RESP. There is no pipelining.

Optional Feature:
Macro RISCV_LSU_MISALIGN_EN.
- Defined:
  - Misaligned accesses are detected at accept: half with addr[0]=1, or word with addr[1:0]≠0.
  - No memory access is issued. State goes IDLE→RESP.
  - misaligned=1 together with done; load_data = 0; no write occurs.
- Undefined:
  - misaligned is tied 0.
  - Low address bits below the access size are ignored: half uses lane addr[1], word uses lane 0.
  - The access is issued normally.

Test Plan:
- SW addr 0x104, wdata 0xDEADBEEF, mem_ready=1 → cycle N+1: mem_addr 0x104, be 1111, wdata 0xDEADBEEF, we=1. Cycle N+2: done=1, stall=0.
- LB addr 0x103, mem_rdata 0x80FF1234 → load_data 0xFFFFFF80. Same access with LBU → 0x00000080. LH addr 0x102, same rdata → 0xFFFF80FF.
- SH addr 0x202, wdata 0x0000ABCD → mem_addr 0x200, be 1100, wdata 0xABCDABCD.
- LW with mem_ready held low 5 cycles → mem_valid and mem_addr stable for 6 cycles, stall high for 7, done exactly once after ready.
- x_reset pulled low during REQ → mem_valid=0 in the same cycle, state IDLE, no done pulse. A fresh SW after release completes normally.
- LW addr 0x101:
  - Macro defined → no mem_valid; misaligned=1 and done=1 at N+1.
  - Macro undefined → mem_addr 0x100 issued, misaligned stays 0.
